// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor: FSM encoding,
// event-counter width and default timing parameters.
package pll_sup_pkg;

   typedef enum logic [1:0] {
      S_PLLRST = 2'd0,
      S_WAIT   = 2'd1,
      S_SETTLE = 2'd2,
      S_RUN    = 2'd3
   } pll_state_e;

   localparam int EVT_CNT_W = 8;

   localparam int DEF_SETTLE_CYCLES  = 1024;
   localparam int DEF_TIMEOUT_CYCLES = 1048576;
   localparam int DEF_PLL_RST_CYCLES = 16;

   // Event counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [EVT_CNT_W-1:0] sat_inc(input logic [EVT_CNT_W-1:0] v);
      return (v == '1) ? v : v + EVT_CNT_W'(1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-high reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a stable lock and only
// then releases the downstream core; retries on timeout and restarts on loss.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_PLLRST | PLL held in reset for PLL_RST_CYCLES
//   S_WAIT   | PLL released, waiting for lock (bounded by TIMEOUT_CYCLES)
//   S_SETTLE | lock seen, must stay high for SETTLE_CYCLES
//   S_RUN    | lock settled, core released; lock loss restarts the PLL
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES
) (
   input  logic                 refclk,
   input  logic                 rst,
   input  logic                 pll_locked,
   output logic                 pll_rst,
   output logic                 sys_reset,
   output logic                 ready,
   output logic [EVT_CNT_W-1:0] retry_cnt,
   output logic [EVT_CNT_W-1:0] lost_cnt,
   output logic [1:0]           state
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [CNT_W-1:0] PLLRST_TC  = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_TC  = CNT_W'(SETTLE_CYCLES - 1);

   pll_state_e       cur_st;
   pll_state_e       nxt_st;
   logic [CNT_W-1:0] cnt;
   logic             lock_s;
   logic             retry_inc;
   logic             lost_inc;

   sync_2ff u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lock_s)
   );

   always_comb begin
      nxt_st    = cur_st;
      retry_inc = 1'b0;
      lost_inc  = 1'b0;
      case (cur_st)
         S_PLLRST: begin
            if (cnt == PLLRST_TC) nxt_st = S_WAIT;
         end
         S_WAIT: begin
            // A lock arriving on the timeout cycle wins over the retry.
            if (lock_s) begin
               nxt_st = S_SETTLE;
            end else if (cnt == TIMEOUT_TC) begin
               nxt_st    = S_PLLRST;
               retry_inc = 1'b1;
            end
         end
         S_SETTLE: begin
            if (!lock_s)                nxt_st = S_WAIT;
            else if (cnt == SETTLE_TC) nxt_st = S_RUN;
         end
         S_RUN: begin
            if (!lock_s) begin
               nxt_st   = S_PLLRST;
               lost_inc = 1'b1;
            end
         end
         default: nxt_st = S_PLLRST;
      endcase
   end

   // Outputs are decoded from nxt_st so they switch on the same edge as state.
   always_ff @(posedge refclk) begin
      if (rst) begin
         cur_st    <= S_PLLRST;
         cnt       <= '0;
         pll_rst   <= 1'b1;
         sys_reset <= 1'b1;
         ready     <= 1'b0;
         retry_cnt <= '0;
         lost_cnt  <= '0;
      end else begin
         cur_st    <= nxt_st;
         pll_rst   <= (nxt_st == S_PLLRST);
         sys_reset <= (nxt_st != S_RUN);
         ready     <= (nxt_st == S_RUN);
         if (nxt_st != cur_st)     cnt <= '0;
         else if (cur_st != S_RUN) cnt <= cnt + CNT_W'(1);
         if (retry_inc) retry_cnt <= sat_inc(retry_cnt);
         if (lost_inc)  lost_cnt  <= sat_inc(lost_cnt);
      end
   end

   assign state = cur_st;

endmodule
